// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-stage PC control bundle: D-stage redirect requests in, F-stage PC state out.
interface fetch_pc_ctrl_if #(
   parameter int unsigned IDX_W = 12
);
   logic             stall;
   logic             br_take;
   logic [15:0]      br_off;
   logic             j_take;
   logic [25:0]      j_idx;
   logic             jr_take;
   logic [31:0]      jr_addr;
   logic [31:0]      d_pc;
   logic [31:0]      pc;
   logic [IDX_W-1:0] im_idx;
   logic             f_valid;
   logic             fault;
   logic [31:0]      fault_pc;
   logic [31:0]      fetch_cnt;

   modport master (
      output stall, br_take, br_off, j_take, j_idx, jr_take, jr_addr, d_pc,
      input  pc, im_idx, f_valid, fault, fault_pc, fetch_cnt
   );

   modport slave (
      input  stall, br_take, br_off, j_take, j_idx, jr_take, jr_addr, d_pc,
      output pc, im_idx, f_valid, fault, fault_pc, fetch_cnt
   );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage program counter: sequential advance, delay-slot redirects,
// stall hold and a sticky fault on illegal fetch targets.
module fetch_pc_ctrl #(
   parameter logic [31:0] PC_RESET = 32'h0000_3000,
   parameter int unsigned IM_WORDS = 4096,
   parameter int unsigned IDX_W    = 12
) (
   input  logic          clk,
   input  logic          rst,
   fetch_pc_ctrl_if.slave bus
);

   // 33-bit bound so a memory ending at the top of the address space still compares correctly
   localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

   typedef enum logic {
      RUN,
      FAULT
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] fpc_q, fpc_d;

   logic [31:0] seq_d;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] target;
   logic        illegal;

   assign seq_d  = bus.d_pc + 32'd4;
   assign br_tgt = seq_d + {{14{bus.br_off[15]}}, bus.br_off, 2'b00};
   assign j_tgt  = {seq_d[31:28], bus.j_idx, 2'b00};

   always_comb begin
      target = pc_q + 32'd4;
      if (bus.jr_take) begin
         target = bus.jr_addr;
      end else if (bus.j_take) begin
         target = j_tgt;
      end else if (bus.br_take) begin
         target = br_tgt;
      end
   end

   assign illegal = (target[1:0] != 2'b00) ||
                    (target < PC_RESET) ||
                    ({1'b0, target} >= PC_LIMIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= PC_RESET;
         cnt_q   <= '0;
         fpc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         fpc_q   <= fpc_d;
      end
   end

   // Stalled cycles skip the legality check entirely; the redirect is re-presented later
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      fpc_d   = fpc_q;
      unique case (state_q)
         RUN: begin
            if (!bus.stall) begin
               if (illegal) begin
                  state_d = FAULT;
                  fpc_d   = target;
               end else begin
                  pc_d  = target;
                  cnt_d = cnt_q + 32'd1;
               end
            end
         end
         FAULT: begin
         end
         default: state_d = FAULT;
      endcase
   end

   assign bus.pc        = pc_q;
   assign bus.im_idx    = IDX_W'((pc_q - PC_RESET) >> 2);
   assign bus.f_valid   = (state_q == RUN);
   assign bus.fault     = (state_q == FAULT);
   assign bus.fault_pc  = fpc_q;
   assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed vectors, an address-level reference model
// checked every cycle, and literal expectations at key points.
module tb_fetch_pc_ctrl;
   localparam int unsigned IDX_W = 12;
   localparam longint BASE  = 64'h3000;
   localparam longint LIMIT = 64'h3000 + 4 * 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_pc_ctrl_if #(.IDX_W(IDX_W)) bus ();

   fetch_pc_ctrl #(
      .PC_RESET(32'h0000_3000),
      .IM_WORDS(4096),
      .IDX_W   (IDX_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: tracks the fetch address as a plain number
   longint m_pc, m_cnt, m_fpc;
   bit     m_fault;
   bit     m_ready = 0;

   function automatic longint pick_target();
      longint t;
      if (bus.jr_take)
         t = longint'(bus.jr_addr);
      else if (bus.j_take)
         t = ((longint'(bus.d_pc) + 4) / (64'd1 << 28)) % 16 * (64'd1 << 28) + longint'(bus.j_idx) * 4;
      else if (bus.br_take)
         t = longint'(bus.d_pc) + 4 + longint'($signed(bus.br_off)) * 4;
      else
         t = m_pc + 4;
      t = t % (64'd1 << 32);
      if (t < 0) t = t + (64'd1 << 32);
      return t;
   endfunction

   always @(posedge clk) begin
      longint t;
      if (rst) begin
         m_pc = BASE; m_cnt = 0; m_fpc = 0; m_fault = 0; m_ready = 1;
      end else if (m_ready && !m_fault && !bus.stall) begin
         t = pick_target();
         if ((t % 4) != 0 || t < BASE || t >= LIMIT) begin
            m_fault = 1;
            m_fpc   = t;
         end else begin
            m_pc  = t;
            m_cnt = (m_cnt + 1) % (64'd1 << 32);
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_ready) begin
         chk("pc",        longint'(bus.pc),        m_pc);
         chk("im_idx",    longint'(bus.im_idx),    (m_pc - BASE) / 4 % 4096);
         chk("f_valid",   longint'(bus.f_valid),   m_fault ? 0 : 1);
         chk("fault",     longint'(bus.fault),     m_fault ? 1 : 0);
         chk("fault_pc",  longint'(bus.fault_pc),  m_fpc);
         chk("fetch_cnt", longint'(bus.fetch_cnt), m_cnt);
      end
   end

   task automatic idle();
      bus.stall = 0; bus.br_take = 0; bus.j_take = 0; bus.jr_take = 0;
      bus.br_off = '0; bus.j_idx = '0; bus.jr_addr = '0; bus.d_pc = '0;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   initial begin
      idle();
      do_reset();
      chk("rst_pc", longint'(bus.pc), 64'h3000);
      chk("rst_idx", longint'(bus.im_idx), 0);
      chk("rst_valid", longint'(bus.f_valid), 1);
      chk("rst_cnt", longint'(bus.fetch_cnt), 0);
      chk("rst_fault", longint'(bus.fault), 0);

      for (int i = 1; i <= 5; i++) begin
         tick(1);
         chk("seq_pc", longint'(bus.pc), 64'h3000 + 4 * i);
         chk("seq_idx", longint'(bus.im_idx), i);
      end
      chk("seq_cnt", longint'(bus.fetch_cnt), 5);

      // branch back by 2 words from D at 0x3008 while F holds 0x300C
      do_reset();
      tick(3);
      chk("pre_br_pc", longint'(bus.pc), 64'h300C);
      bus.d_pc = 32'h3008; bus.br_off = 16'hFFFE; bus.br_take = 1;
      tick(1);
      idle();
      chk("br_pc", longint'(bus.pc), 64'h3004);
      chk("br_cnt", longint'(bus.fetch_cnt), 4);

      tick(3);
      chk("pre_stall_pc", longint'(bus.pc), 64'h3010);
      bus.stall = 1;
      tick(1);
      bus.j_take = 1; bus.j_idx = 26'h0000C80; bus.d_pc = 32'h3008;
      tick(1);
      bus.j_take = 0;
      tick(1);
      chk("stall_pc", longint'(bus.pc), 64'h3010);
      chk("stall_cnt", longint'(bus.fetch_cnt), 7);
      chk("stall_valid", longint'(bus.f_valid), 1);
      idle();
      tick(1);
      chk("unstall_pc", longint'(bus.pc), 64'h3014);

      // all three takes together: jr wins
      bus.jr_take = 1; bus.jr_addr = 32'h3100;
      bus.j_take = 1; bus.j_idx = 26'h0000D00;
      bus.br_take = 1; bus.d_pc = 32'h3014; bus.br_off = 16'h0004;
      tick(1);
      idle();
      chk("prio_pc", longint'(bus.pc), 64'h3100);
      chk("prio_cnt", longint'(bus.fetch_cnt), 9);

      bus.j_take = 1; bus.j_idx = 26'h0000C80; bus.br_take = 1; bus.d_pc = 32'h3100;
      tick(1);
      idle();
      chk("j_pc", longint'(bus.pc), 64'h3200);
      chk("j_idx_out", longint'(bus.im_idx), 64'h080);

      bus.jr_take = 1; bus.jr_addr = 32'h3002;
      tick(1);
      idle();
      chk("flt", longint'(bus.fault), 1);
      chk("flt_pc", longint'(bus.fault_pc), 64'h3002);
      chk("flt_valid", longint'(bus.f_valid), 0);
      chk("flt_hold", longint'(bus.pc), 64'h3200);
      chk("flt_cnt", longint'(bus.fetch_cnt), 10);

      bus.jr_take = 1; bus.jr_addr = 32'h3100;
      tick(2);
      bus.stall = 1;
      tick(1);
      idle();
      tick(1);
      chk("flt_sticky", longint'(bus.fault), 1);
      chk("flt_sticky_pc", longint'(bus.pc), 64'h3200);
      chk("flt_sticky_fpc", longint'(bus.fault_pc), 64'h3002);

      do_reset();
      chk("flt_rst_pc", longint'(bus.pc), 64'h3000);
      chk("flt_rst_fault", longint'(bus.fault), 0);
      chk("flt_rst_fpc", longint'(bus.fault_pc), 0);

      bus.jr_take = 1; bus.jr_addr = 32'h6FFC;
      tick(1);
      idle();
      chk("end_pc", longint'(bus.pc), 64'h6FFC);
      chk("end_idx", longint'(bus.im_idx), 64'hFFF);
      tick(1);
      chk("wrap_fault", longint'(bus.fault), 1);
      chk("wrap_fpc", longint'(bus.fault_pc), 64'h7000);
      chk("wrap_pc", longint'(bus.pc), 64'h6FFC);

      // below-base target, and reset taking priority mid-stall
      do_reset();
      bus.br_take = 1; bus.d_pc = 32'h3000; bus.br_off = 16'hFFFC;
      tick(1);
      idle();
      chk("low_fault", longint'(bus.fault), 1);
      chk("low_fpc", longint'(bus.fault_pc), 64'h2FF4);
      do_reset();
      tick(2);
      bus.stall = 1;
      rst = 1;
      tick(1);
      rst = 0;
      chk("rst_stall_pc", longint'(bus.pc), 64'h3000);
      idle();
      tick(2);
      chk("post_pc", longint'(bus.pc), 64'h3008);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
